// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: FSM state codes,
// the zero-register index and default parameter values.
package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_ERR      = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int unsigned MEM_TIMEOUT_DEF = 15;
  localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
// Counts consecutive data-memory wait cycles and pulses timeout_o on the
// cycle that the count reaches MEM_TIMEOUT while the access is still pending.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic wait_i,
  output logic timeout_o
);

  localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [TW-1:0] timer_q, timer_d;

  assign timeout_o = wait_i && (timer_q == TW'(MEM_TIMEOUT));

  always_comb begin
    timer_d = '0;
    if (start_i) begin
      timer_d = TW'(1);
    end else if (wait_i && !timeout_o) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// data-memory wait freezes. Optional counters: define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             memwb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  logic [1:0] state_q, state_d;
  logic       err_q;
  logic       lu, mw;
  logic       hard_freeze, mw_freeze, run_rules;
  logic       timeout;

  assign lu = ex_memread && (ex_rt != REG_ZERO) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mw = mem_req && !dmem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  ((state_q == ST_RUN) && mw),
    .wait_i   ((state_q == ST_MEM_WAIT) && !dmem_ready),
    .timeout_o(timeout)
  );

  // Classify the cycle first; the release cycle out of MEM_WAIT reuses the RUN rules.
  always_comb begin
    state_d     = state_q;
    hard_freeze = 1'b0;
    mw_freeze   = 1'b0;
    run_rules   = 1'b0;
    if (!rst_n) begin
      hard_freeze = 1'b1;
      state_d     = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mw) begin
            mw_freeze = 1'b1;
            state_d   = ST_MEM_WAIT;
          end else begin
            run_rules = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            run_rules = 1'b1;
            state_d   = ST_RUN;
          end else begin
            mw_freeze = 1'b1;
            if (timeout) state_d = ST_ERR;
          end
        end
        default: begin
          hard_freeze = 1'b1;
          state_d     = ST_ERR;
        end
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    memwb_bubble = 1'b0;
    if (hard_freeze || mw_freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
      idex_bubble  = hard_freeze;
    end else if (run_rules) begin
      if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, wait_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      if (run_rules && !ex_branch_taken && lu && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (mw_freeze && (wait_cnt_q != '1))
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign wait_cnt  = wait_cnt_q;
`else
  assign stall_cnt = '0;
  assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MT = 15;
  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, ex_memread, ex_branch_taken, mem_req, dmem_ready;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic exmem_write, memwb_bubble, mem_timeout_err;
  logic [CW-1:0] stall_cnt, wait_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
    .memwb_bubble(memwb_bubble), .mem_timeout_err(mem_timeout_err),
    .stall_cnt(stall_cnt), .wait_cnt(wait_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the pipeline is either free, held by a pending memory access,
  // or dead after MT+1 consecutive frozen cycles.
  bit m_valid = 0;
  bit m_holding, m_dead, m_err;
  int m_frozen_run, m_stalls, m_waits;

  function automatic bit load_use();
    return ex_memread && ex_rt != 0 &&
           (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
  endfunction

  function automatic bit frozen_now();
    return m_holding ? !dmem_ready : (mem_req && !dmem_ready);
  endfunction

  // {pc, ifid, flush, idex_w, idex_b, exmem, memwb_b}
  function automatic logic [6:0] expected_ctl();
    if (!rst_n || m_dead)       return 7'b0000101;
    if (frozen_now())           return 7'b0000001;
    if (ex_branch_taken)        return 7'b1111110;
    if (load_use())             return 7'b0001110;
    return 7'b1101010;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1; m_holding = 0; m_dead = 0; m_err = 0;
      m_frozen_run = 0; m_stalls = 0; m_waits = 0;
    end else if (m_valid && !m_dead) begin
      if (frozen_now()) begin
        m_frozen_run++;
        if (m_waits < CMAX) m_waits++;
        if (m_frozen_run == MT + 1) begin
          m_dead = 1; m_err = 1; m_holding = 0;
        end else begin
          m_holding = 1;
        end
      end else begin
        m_holding = 0;
        m_frozen_run = 0;
        if (!ex_branch_taken && load_use() && m_stalls < CMAX) m_stalls++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ctl", int'({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                       exmem_write, memwb_bubble}), int'(expected_ctl()));
      chk("err", int'(mem_timeout_err), int'(m_err));
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt", int'(stall_cnt), m_stalls);
      chk("wait_cnt", int'(wait_cnt), m_waits);
`else
      chk("stall_cnt", int'(stall_cnt), 0);
      chk("wait_cnt", int'(wait_cnt), 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 0; ex_memread = 0; ex_rt = 5'd3;
    ex_branch_taken = 0; mem_req = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    #1;
    tick();
    #3;
    chk("rst_pc_write", int'(pc_write), 0);
    chk("rst_idex_bubble", int'(idex_bubble), 1);
    chk("rst_memwb_bubble", int'(memwb_bubble), 1);
    chk("rst_err", int'(mem_timeout_err), 0);
    tick();
    rst_n = 1;
    #3;
    chk("run_default_pc", int'(pc_write), 1);
    chk("run_default_bubble", int'(idex_bubble), 0);
    tick();

    // load-use on rs, then EX holds the bubble
    ex_memread = 1; ex_rt = 5'd5; id_rs = 5'd5;
    #3;
    chk("lu_pc_write", int'(pc_write), 0);
    chk("lu_ifid_write", int'(ifid_write), 0);
    chk("lu_idex_bubble", int'(idex_bubble), 1);
    tick();
    ex_memread = 0;
    #3;
    chk("lu_after_pc", int'(pc_write), 1);
    tick();
    ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0;
    #3;
    chk("lu_r0_pc", int'(pc_write), 1);
    tick();

    // rt gating
    ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd1; id_uses_rt = 0;
    #3;
    chk("rt_unused_pc", int'(pc_write), 1);
    tick();
    id_uses_rt = 1;
    #3;
    chk("rt_used_pc", int'(pc_write), 0);
    tick();

    // branch overrides load-use
    do_reset();
    idle();
    ex_branch_taken = 1; ex_memread = 1; ex_rt = 5'd5; id_rs = 5'd5;
    #3;
    chk("br_flush", int'(ifid_flush), 1);
    chk("br_bubble", int'(idex_bubble), 1);
    chk("br_pc", int'(pc_write), 1);
    tick();
    chk("br_stall_cnt", int'(stall_cnt), 0);

    // three-cycle memory wait
    do_reset();
    idle();
    mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("mw_memwb_bubble", int'(memwb_bubble), 1);
      chk("mw_exmem_write", int'(exmem_write), 0);
      tick();
    end
    dmem_ready = 1;
    #3;
    chk("mw_release_pc", int'(pc_write), 1);
    tick();
`ifdef HAZARD_PERF_CNT_EN
    chk("mw_wait_cnt", int'(wait_cnt), 3);
`else
    chk("mw_wait_cnt", int'(wait_cnt), 0);
`endif
    mem_req = 0;
    #3;
    chk("mw_back_run", int'(exmem_write), 1);
    tick();

    // timeout into ERR, sticky until reset
    mem_req = 1; dmem_ready = 0;
    repeat (18) tick();
    chk("to_err", int'(mem_timeout_err), 1);
`ifdef HAZARD_PERF_CNT_EN
    chk("to_wait_sat", int'(wait_cnt), int'(CMAX));
`endif
    mem_req = 0; dmem_ready = 1;
    #3;
    chk("err_frozen_pc", int'(pc_write), 0);
    tick();
    chk("err_sticky", int'(mem_timeout_err), 1);
    do_reset();
    #3;
    chk("err_cleared", int'(mem_timeout_err), 0);
    chk("err_reset_pc", int'(pc_write), 1);
    tick();

    // reset in the middle of a wait
    mem_req = 1; dmem_ready = 0;
    repeat (3) tick();
    rst_n = 0;
    #3;
    chk("rmw_idex_bubble", int'(idex_bubble), 1);
    chk("rmw_pc", int'(pc_write), 0);
    tick();
    rst_n = 1; mem_req = 0; dmem_ready = 1;
    #3;
    chk("rmw_run_pc", int'(pc_write), 1);
    chk("rmw_run_bubble", int'(idex_bubble), 0);
    chk("rmw_wait_cnt", int'(wait_cnt), 0);
    tick();

    // randomized traffic, with periodic long waits and resets
    for (int j = 0; j < 3000; j++) begin
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_memread = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 99) < 15);
      mem_req = ($urandom_range(0, 99) < 30);
      dmem_ready = ($urandom_range(0, 9) < 7);
      if ((j % 700) >= 600 && (j % 700) < 620) dmem_ready = 0;
      rst_n = !((j % 700) == 630 || $urandom_range(0, 199) == 0);
      tick();
    end

    rst_n = 1;
    idle();
    tick();
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
